// File: rtl/cpu7_ifu_imem_pkg.sv
// cpu7_ifu_imem_pkg
//   Shared constants and helpers for the IFU instruction-memory responder:
//   fetch line width, the ADEF exception code, the responder state type and
//   the fetch-line rotate helper.
package cpu7_ifu_imem_pkg;

  localparam int LINE_W = 128;
  localparam logic [5:0] EXC_ADEF = 6'h08;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Word w of the line lands in slot 0; slots past word 3 fill with zeros.
  function automatic logic [LINE_W-1:0] rotate_line(input logic [LINE_W-1:0] line,
                                                     input logic [1:0]        word);
    return line >> {word, 5'b00000};
  endfunction

  // Number of valid words after rotation, minus one.
  function automatic logic [1:0] word_count(input logic [1:0] word);
    return 2'd3 - word;
  endfunction

endpackage

// File: rtl/cpu7_ifu_imem_if.sv
// cpu7_ifu_imem_if
//   Fetch request/response bundle between the IFU fetch datapath (master)
//   and the instruction-memory responder (slave).
//   master drives : inst_req, inst_addr, inst_cancel
//   slave drives  : inst_addr_ok, inst_valid, inst_rdata, inst_count,
//                   inst_ex, inst_exccode, inst_uncache
interface cpu7_ifu_imem_if;
  import cpu7_ifu_imem_pkg::*;

  logic              inst_req;
  logic [31:0]       inst_addr;
  logic              inst_addr_ok;
  logic              inst_cancel;
  logic              inst_valid;
  logic [LINE_W-1:0] inst_rdata;
  logic [1:0]        inst_count;
  logic              inst_ex;
  logic [5:0]        inst_exccode;
  logic              inst_uncache;

  modport master (
    output inst_req, inst_addr, inst_cancel,
    input  inst_addr_ok, inst_valid, inst_rdata, inst_count,
           inst_ex, inst_exccode, inst_uncache
  );

  modport slave (
    input  inst_req, inst_addr, inst_cancel,
    output inst_addr_ok, inst_valid, inst_rdata, inst_count,
           inst_ex, inst_exccode, inst_uncache
  );

endinterface

// File: rtl/cpu7_ifu_imem_ram.sv
// cpu7_ifu_imem_ram
//   2^DEPTH_LOG2 x 128-bit line array, one synchronous read port with an
//   enable-held read register, one write port.
//   clock, reset_l       : clock / async active-low reset (read register only)
//   re, raddr -> rdata   : read issued on an edge, data held until next read
//   we, waddr, wdata     : write, visible from the following edge
//   A read and a write to the same line on one edge return the old data.
module cpu7_ifu_imem_ram
  import cpu7_ifu_imem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clock,
  input  logic                  reset_l,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [LINE_W-1:0]     wdata,
  output logic [LINE_W-1:0]     rdata
);

  logic [LINE_W-1:0] mem [0:(2**DEPTH_LOG2)-1];
  logic [LINE_W-1:0] rdata_r;

  // Array write port; contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register: loads on a read, otherwise holds for multi-cycle latency.
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      rdata_r <= {LINE_W{1'b0}};
    end else if (re) begin
      rdata_r <= mem[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/cpu7_ifu_imem.sv
// cpu7_ifu_imem
//   Instruction-side responder for the IFU fetch interface. Accepts one
//   fetch at a time, answers with a rotated 128-bit line LAT cycles later,
//   honours inst_cancel and reports ADEF on misaligned or out-of-window
//   addresses. A side port preloads the array.
//   clock, reset_l          : clock / async active-low reset
//   ifu (slave modport)     : fetch request/response bundle
//   mem_we/mem_waddr/wdata  : preload write port
module cpu7_ifu_imem
  import cpu7_ifu_imem_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE       = 32'h1c00_0000,
  parameter int          LAT        = 1,
  parameter logic        UNCACHE    = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset_l,
  cpu7_ifu_imem_if.slave        ifu,
  input  logic                  mem_we,
  input  logic [DEPTH_LOG2-1:0] mem_waddr,
  input  logic [LINE_W-1:0]     mem_wdata
);

  localparam int         TAG_LSB  = DEPTH_LOG2 + 4;
  localparam logic [1:0] CNT_LOAD = 2'(LAT - 1);

  state_e            state_r, state_nxt;
  logic [1:0]        cnt_r, cnt_nxt;
  logic [1:0]        word_r;
  logic              ex_r;

  logic              addr_ex_s;
  logic              busy_done_s;
  logic              addr_ok_s;
  logic              accept_s;
  logic              resp_s;
  logic [LINE_W-1:0] line_s;

  logic              valid_s;
  logic [LINE_W-1:0] rdata_s;
  logic [1:0]        count_s;
  logic              ex_s;
  logic [5:0]        exccode_s;
  logic              uncache_s;

  assign addr_ex_s   = (ifu.inst_addr[1:0] != 2'b00) |
                       (ifu.inst_addr[31:TAG_LSB] != BASE[31:TAG_LSB]);
  assign busy_done_s = (state_r == ST_BUSY) & (cnt_r == 2'd0);
  // Cancel frees the slot immediately so a same-cycle request is taken fresh.
  assign addr_ok_s   = reset_l & ((state_r == ST_IDLE) | busy_done_s | ifu.inst_cancel);
  assign accept_s    = ifu.inst_req & addr_ok_s;
  assign resp_s      = busy_done_s & ~ifu.inst_cancel;

  // Faulting fetches never touch the array.
  cpu7_ifu_imem_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clock   (clock),
    .reset_l (reset_l),
    .re      (accept_s & ~addr_ex_s),
    .raddr   (ifu.inst_addr[TAG_LSB-1:4]),
    .we      (mem_we),
    .waddr   (mem_waddr),
    .wdata   (mem_wdata),
    .rdata   (line_s)
  );

  // State and latency counter.
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      state_r <= ST_IDLE;
      cnt_r   <= 2'd0;
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
    end
  end

  // Next state: a new accept always (re)starts the countdown.
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    if (accept_s) begin
      state_nxt = ST_BUSY;
      cnt_nxt   = CNT_LOAD;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = 2'd0;
        end
        ST_BUSY: begin
          if (ifu.inst_cancel || (cnt_r == 2'd0)) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = 2'd0;
          end else begin
            state_nxt = ST_BUSY;
            cnt_nxt   = cnt_r - 2'd1;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = 2'd0;
        end
      endcase
    end
  end

  // Per-transaction fields captured at acceptance.
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      word_r <= 2'd0;
      ex_r   <= 1'b0;
    end else if (accept_s) begin
      word_r <= ifu.inst_addr[3:2];
      ex_r   <= addr_ex_s;
    end
  end

  // Response muxing: everything is zero outside the response cycle.
  always_comb begin
    valid_s   = 1'b0;
    rdata_s   = {LINE_W{1'b0}};
    count_s   = 2'd0;
    ex_s      = 1'b0;
    exccode_s = 6'h00;
    uncache_s = 1'b0;
    if (resp_s) begin
      valid_s   = 1'b1;
      uncache_s = UNCACHE;
      if (ex_r) begin
        ex_s      = 1'b1;
        exccode_s = EXC_ADEF;
      end else begin
        rdata_s   = rotate_line(line_s, word_r);
        count_s   = word_count(word_r);
      end
    end else begin
      valid_s   = 1'b0;
    end
  end

  assign ifu.inst_addr_ok = addr_ok_s;
  assign ifu.inst_valid   = valid_s;
  assign ifu.inst_rdata   = rdata_s;
  assign ifu.inst_count   = count_s;
  assign ifu.inst_ex      = ex_s;
  assign ifu.inst_exccode = exccode_s;
  assign ifu.inst_uncache = uncache_s;

endmodule

// File: tb/tb_cpu7_ifu_imem.sv
// tb_cpu7_ifu_imem
//   Four responders (LAT = 1..4, UNCACHE alternating) share clock, reset and
//   the preload port; each gets its own random fetch/cancel traffic.
//   A driver per lane computes the expected response from the address and a
//   line-array model and queues it with its due cycle; a monitor per lane
//   pops and compares whenever inst_valid is seen.
module tb_cpu7_ifu_imem;

  localparam int          DL     = 10;
  localparam logic [31:0] BASE_A = 32'h1c00_0000;
  localparam int          NCYC   = 1500;
  localparam int          RST0   = 20;

  typedef struct {
    int           due;
    logic [127:0] data;
    logic [1:0]   count;
    logic         ex;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset_l;
  logic          mem_we;
  logic [DL-1:0] mem_waddr;
  logic [127:0]  mem_wdata;

  logic [127:0]  mem_model [0:(2**DL)-1];
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  int            done_cnt = 0;

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected response for a fetch of address a, from the current array image.
  function automatic exp_t model(input logic [31:0] a, input int due);
    exp_t         e;
    logic [127:0] line;
    int           w;
    e.due   = due;
    e.data  = 128'd0;
    e.count = 2'd0;
    e.ex    = (a[1:0] != 2'b00) || (a[31:DL+4] != BASE_A[31:DL+4]);
    if (!e.ex) begin
      line = mem_model[a[DL+3:4]];
      w    = int'(a[3:2]);
      for (int k = 0; k < 4 - w; k++) e.data[32*k +: 32] = line[32*(w+k) +: 32];
      e.count = 2'(3 - w);
    end
    return e;
  endfunction

  // Preload lines 0..15 during reset, then sprinkle random rewrites.
  initial begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      mem_we    = 1'b1;
      mem_waddr = DL'(i);
      mem_wdata = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clock);
      mem_model[i] = mem_wdata;
    end
    for (int i = 0; i < NCYC - 40; i++) begin
      @(negedge clock);
      mem_we    = ($urandom_range(0, 9) == 0);
      mem_waddr = DL'($urandom_range(0, 15));
      mem_wdata = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clock);
      if (mem_we) mem_model[mem_waddr] = mem_wdata;
    end
    @(negedge clock);
    mem_we = 1'b0;
  end

  for (genvar g = 0; g < 4; g++) begin : lane
    localparam int   L  = g + 1;
    localparam logic UC = 1'(g % 2);

    cpu7_ifu_imem_if bus();
    exp_t q[$];

    cpu7_ifu_imem #(
      .DEPTH_LOG2 (DL),
      .BASE       (BASE_A),
      .LAT        (L),
      .UNCACHE    (UC)
    ) dut (
      .clock     (clock),
      .reset_l   (reset_l),
      .ifu       (bus),
      .mem_we    (mem_we),
      .mem_waddr (mem_waddr),
      .mem_wdata (mem_wdata)
    );

    // Driver: random fetch/cancel, addr_ok check, expected-response queueing.
    initial begin
      logic [31:0] a;
      int          kind;
      bit          pend_busy;
      logic        exp_ok;
      bus.inst_req    = 1'b0;
      bus.inst_addr   = 32'd0;
      bus.inst_cancel = 1'b0;
      for (int i = 0; i < NCYC; i++) begin
        @(negedge clock);
        kind = $urandom_range(0, 9);
        a    = BASE_A + 32'($urandom_range(0, 15) * 16 + $urandom_range(0, 3) * 4);
        if (kind == 8) a[1:0] = 2'($urandom_range(1, 3));
        if (kind == 9) begin
          a = ($urandom_range(0, 1) == 0) ? 32'h2000_0000 : $urandom;
          if (a[31:DL+4] == BASE_A[31:DL+4]) a[31] = ~a[31];
        end
        bus.inst_addr   = a;
        bus.inst_req    = (i < RST0) ? 1'b1 : ($urandom_range(0, 9) < 7);
        bus.inst_cancel = ($urandom_range(0, 19) < 3);
        #1;
        // Busy means a transaction is still counting down past this cycle.
        pend_busy = (q.size() > 0) && (q[0].due > cyc);
        exp_ok    = reset_l && (!pend_busy || bus.inst_cancel);
        chk($sformatf("addr_ok[lat%0d]", L), 128'(bus.inst_addr_ok), 128'(exp_ok));
        if (!reset_l) begin
          q.delete();
        end else begin
          if (bus.inst_cancel) begin
            while (q.size() > 0 && q[q.size()-1].due >= cyc) void'(q.pop_back());
          end
          if (bus.inst_req && exp_ok) q.push_back(model(a, cyc + L));
        end
      end
      @(negedge clock);
      bus.inst_req    = 1'b0;
      bus.inst_cancel = 1'b0;
      repeat (8) @(negedge clock);
      #3;
      chk($sformatf("drained[lat%0d]", L), 128'(q.size()), 128'd0);
      done_cnt++;
    end

    // Monitor: compare every presented response against the queue head.
    initial begin
      exp_t e;
      forever begin
        @(negedge clock);
        #2;
        if (bus.inst_valid === 1'b1) begin
          if (q.size() == 0 || q[0].due != cyc) begin
            chk($sformatf("unexpected_valid[lat%0d]", L), 128'(bus.inst_valid), 128'd0);
          end else begin
            e = q.pop_front();
            chk($sformatf("rdata[lat%0d]", L), bus.inst_rdata, e.data);
            chk($sformatf("count[lat%0d]", L), 128'(bus.inst_count), 128'(e.count));
            chk($sformatf("ex[lat%0d]", L), 128'(bus.inst_ex), 128'(e.ex));
            chk($sformatf("exccode[lat%0d]", L), 128'(bus.inst_exccode),
                e.ex ? 128'h08 : 128'h00);
            chk($sformatf("uncache[lat%0d]", L), 128'(bus.inst_uncache), 128'(UC));
          end
        end else begin
          chk($sformatf("idle_rdata[lat%0d]", L), bus.inst_rdata, 128'd0);
          chk($sformatf("idle_side[lat%0d]", L),
              128'({bus.inst_count, bus.inst_ex, bus.inst_exccode, bus.inst_uncache}), 128'd0);
          if (q.size() > 0 && q[0].due == cyc) begin
            chk($sformatf("missing_valid[lat%0d]", L), 128'(bus.inst_valid), 128'd1);
            void'(q.pop_front());
          end
        end
      end
    end
  end

  // Reset sequencing: long initial reset, one reset mid-traffic, then wrap-up.
  initial begin
    reset_l = 1'b0;
    repeat (RST0) @(negedge clock);
    reset_l = 1'b1;
    repeat (600) @(negedge clock);
    reset_l = 1'b0;
    repeat (3) @(negedge clock);
    reset_l = 1'b1;
    for (int t = 0; t < NCYC + 200 && done_cnt < 4; t++) @(negedge clock);
    #4;
    chk("all_lanes_done", 128'(done_cnt), 128'd4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu7_ifu_imem.md
# cpu7_ifu_imem

Instruction-side responder for the IFU fetch interface: accepts `inst_req`/`inst_addr` from the fetch datapath and returns 128-bit fetch lines after a programmable latency. It honours `inst_cancel` and flags address exceptions. It serves as the on-chip instruction memory for bring-up and simulation, and as the reference responder against which the fetch datapath is verified. A side write port preloads the array.

## Interface
- `DEPTH_LOG2`, 10: log2 of the number of 128-bit lines (16 KiB default).
- `BASE`, 32'h1c00_0000: byte address of line 0; must be aligned to 2^(DEPTH_LOG2+4).
- `LAT`, 1: cycles from acceptance to `inst_valid`; legal range 1..4.
- `UNCACHE`, 1'b0: constant value returned on `inst_uncache`.
- `clock` in 1: sole clock; all state on rising edge.
- `reset_l` in 1: asynchronous, active-low reset.
- `inst_req` in 1: fetch request.
- `inst_addr` in 32: fetch byte address.
- `inst_addr_ok` out 1: request accepted this cycle when high together with `inst_req`.
- `inst_cancel` in 1: kill the in-flight request.
- `inst_valid` out 1: response valid, one cycle per accepted non-cancelled request.
- `inst_rdata` out 128: rotated fetch line.
- `inst_count` out 2: number of valid words in `inst_rdata` minus 1.
- `inst_ex` out 1: address exception on this response.
- `inst_exccode` out 6: exception code; ADEF when `inst_ex` is high, otherwise 0.
- `inst_uncache` out 1: equals `UNCACHE` when `inst_valid` is high, otherwise 0.
- `mem_we` in 1: preload write enable.
- `mem_waddr` in DEPTH_LOG2: preload line index.
- `mem_wdata` in 128: preload line data.

## Operation
- State machine: IDLE, BUSY. A down-counter `cnt` (2 bits) is active in BUSY.
- `inst_addr_ok` = `reset_l` & (IDLE | (BUSY & cnt==0) | `inst_cancel`). This is combinational and allows back-to-back acceptance.
- Accept means `inst_req & inst_addr_ok`. On accept:
  - latch `inst_addr[3:2]` and the exception flag;
  - issue a synchronous read of line `inst_addr[DEPTH_LOG2+3:4]`;
  - go to BUSY with cnt = LAT-1.
- Exception when `inst_addr[1:0]` ≠ 0, or when `inst_addr[31:DEPTH_LOG2+4]` ≠ `BASE[31:DEPTH_LOG2+4]`. On exception:
  - `inst_ex`=1, `inst_exccode`=6'h08 (ADEF);
  - `inst_rdata`=0, `inst_count`=0;
  - the array is not read.
- Rotation, with w = latched `addr[3:2]`:
  - `inst_rdata[31:0]` = word w, `[63:32]` = word w+1, and so on up to word 3;
  - unused upper slots are 0;
  - `inst_count` = 3 − w.
- Response: `inst_valid` = BUSY & cnt==0 & ~`inst_cancel`. In the response cycle:
  - with a new accept, stay in BUSY with cnt reloaded;
  - otherwise go to IDLE.
- Cancel while BUSY drops the pending response; no `inst_valid` is ever produced for it. If a request is present in the same cycle, it is accepted as a fresh transaction. Without a request, go to IDLE.
- Cancel in IDLE without a request has no effect.
- At most one transaction is in flight.
- Preload writes take effect on the next edge. A write to a line being read in the same cycle returns the old data.
- All response outputs are 0 when `inst_valid` is low.

## Timing
- Reset (`reset_l`=0, asynchronous): state IDLE, cnt=0, latched fields 0. All outputs are 0, including `inst_addr_ok`. Array contents are not reset.
- Reset deasserting: `inst_addr_ok`=1 in the first cycle after deassertion.
- Latency: accept at edge t, `inst_valid` high during cycle t+LAT.
- Sustained throughput: one response per cycle when LAT=1, one per LAT cycles otherwise.
- Reset asserted mid-transaction: the transaction is lost and no response follows.

## Structure
- `common.vh` gains the ADEF exccode constant (6'h08) and the fetch line width (128).
- Sub-module `cpu7_ifu_imem_ram`: 2^DEPTH_LOG2 × 128 array with one synchronous read port and one write port.
- The read-data register sits in the RAM; the rotate, mask and exception muxing is in the top level.
- Built from the existing `dff`/`dffe` primitives, using async-reset variants.

## Test plan
- Reset and single fetch:
  - stimulus: hold `reset_l` low 3 cycles with `inst_req`=1;
  - required during reset: all outputs 0;
  - stimulus after release: preload line 0 with words {D,C,B,A}, LAT=2, fetch 0x1c00_0008;
  - required: `inst_valid` 2 cycles after accept, rdata = {0,0,D,C}, count=1.
- Back-to-back at LAT=1:
  - stimulus: addresses 0x1c00_0000, 0x1c00_0010, 0x1c00_0020 on consecutive cycles;
  - required: `inst_addr_ok` high every cycle, three consecutive `inst_valid` cycles, count=3 each, lines in order.
- Cancel mid-flight at LAT=3:
  - stimulus: fetch 0x1c00_0000, pulse `inst_cancel` one cycle later together with a request to 0x1c00_0040;
  - required: only one `inst_valid`, carrying line 4, 3 cycles after the cancel.
- Cancel in the response cycle:
  - stimulus: cancel with no new request in the response cycle;
  - required: `inst_valid` stays 0 and the state is IDLE.
- Exceptions:
  - stimulus: fetch 0x1c00_0002, then fetch 0x2000_0000;
  - required: each response has `inst_ex`=1, exccode=6'h08, rdata=0.
- Reset mid-op:
  - stimulus: assert `reset_l` low during BUSY at LAT=4;
  - required: no `inst_valid` afterwards, `inst_addr_ok`=0 while held in reset, normal operation after release.
